// File: rtl/spi_reg_pkg.sv
// spi_reg_pkg
//   Shared definitions for the SPI register-access controller.
//   - state_t        : controller FSM states
//   - CMD_*          : command byte field positions for the default 8-bit geometry
//                      (1 rw bit, 3 length bits, 4 address bits)
//   - CS_MIN_HIGH    : minimum cs high time, in clk periods, between read bytes
package spi_reg_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        LOAD  = 2'd2,
        DATA  = 2'd3
    } state_t;

    localparam int CMD_RW_BIT   = 7;
    localparam int CMD_LEN_LSB  = 4;
    localparam int CMD_ADDR_LSB = 0;

    localparam int CS_MIN_HIGH  = 6;

endpackage

// File: rtl/cs_edge_sync.sv
// cs_edge_sync
//   Brings the raw SPI chip select into the clk domain and produces
//   single-cycle edge pulses.
//   Ports:
//     clk     in  : system clock
//     rst     in  : synchronous active-high reset
//     cs      in  : raw chip select, active low, asynchronous to clk
//     cs_rise out : one-cycle pulse after a synchronised low-to-high transition
//     cs_fall out : one-cycle pulse after a synchronised high-to-low transition
module cs_edge_sync (
    input  logic clk,
    input  logic rst,
    input  logic cs,
    output logic cs_rise,
    output logic cs_fall
);

    logic sync1;
    logic sync2;
    logic prev;

    // Two synchroniser flops followed by a history flop for edge detection.
    // Everything resets to 1 (deselected) so leaving reset never looks like an edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
            prev  <= 1'b1;
        end else begin
            sync1 <= cs;
            sync2 <= sync1;
            prev  <= sync2;
        end
    end

    assign cs_rise = sync2 & ~prev;
    assign cs_fall = ~sync2 & prev;

endmodule

// File: rtl/spi_reg_ctrl.sv
// spi_reg_ctrl
//   Sequences a byte-wide SPI slave shift register against a small register
//   bus. The first byte of a transfer is a command {rw, len-1, addr}; the
//   following bytes are burst data, with the address incrementing (and
//   wrapping) after each byte.
//   Ports:
//     clk        in  : system clock
//     rst        in  : synchronous active-high reset
//     cs         in  : raw SPI chip select, active low, asynchronous
//     spi_p_out  in  : byte received by the SPI slave
//     spi_p_in   out : byte the SPI slave transmits (captured on cs fall)
//     status     in  : status byte returned while idle
//     err_clr    in  : pulse that clears err
//     reg_addr   out : register bus address
//     reg_wdata  out : register write data
//     reg_we     out : one-cycle write strobe
//     reg_re     out : one-cycle read strobe
//     reg_rdata  in  : read data, valid the cycle after reg_re
//     busy       out : high whenever the FSM is not idle
//     err        out : sticky overrun flag
module spi_reg_ctrl
    import spi_reg_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int ADDR_W = 4,
    parameter int LEN_W  = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cs,
    input  logic [WIDTH-1:0]  spi_p_out,
    output logic [WIDTH-1:0]  spi_p_in,
    input  logic [WIDTH-1:0]  status,
    input  logic              err_clr,
    output logic [ADDR_W-1:0] reg_addr,
    output logic [WIDTH-1:0]  reg_wdata,
    output logic              reg_we,
    output logic              reg_re,
    input  logic [WIDTH-1:0]  reg_rdata,
    output logic              busy,
    output logic              err
);

    logic cs_rise;
    logic cs_fall;

    cs_edge_sync u_cs_edge_sync (
        .clk     (clk),
        .rst     (rst),
        .cs      (cs),
        .cs_rise (cs_rise),
        .cs_fall (cs_fall)
    );

    state_t            state, state_n;
    logic [ADDR_W-1:0] addr, addr_n;
    logic [LEN_W-1:0]  remaining, remaining_n;
    logic              is_read, is_read_n;
    logic [WIDTH-1:0]  spi_p_in_n;
    logic [WIDTH-1:0]  reg_wdata_n;
    logic [ADDR_W-1:0] reg_addr_n;
    logic              reg_we_n;
    logic              reg_re_n;
    logic              err_n;

    // State, counters and all bus-facing outputs are registered here.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            addr      <= '0;
            remaining <= '0;
            is_read   <= 1'b0;
            spi_p_in  <= '0;
            reg_addr  <= '0;
            reg_wdata <= '0;
            reg_we    <= 1'b0;
            reg_re    <= 1'b0;
            err       <= 1'b0;
        end else begin
            state     <= state_n;
            addr      <= addr_n;
            remaining <= remaining_n;
            is_read   <= is_read_n;
            spi_p_in  <= spi_p_in_n;
            reg_addr  <= reg_addr_n;
            reg_wdata <= reg_wdata_n;
            reg_we    <= reg_we_n;
            reg_re    <= reg_re_n;
            err       <= err_n;
        end
    end

    // Next-state logic. Strobes are computed one cycle early so they appear
    // registered: reg_re is high while the FSM sits in FETCH, and reg_we is
    // high in the cycle after the data byte's cs_rise.
    always_comb begin
        state_n     = state;
        addr_n      = addr;
        remaining_n = remaining;
        is_read_n   = is_read;
        spi_p_in_n  = spi_p_in;
        reg_addr_n  = reg_addr;
        reg_wdata_n = reg_wdata;
        reg_we_n    = 1'b0;
        reg_re_n    = 1'b0;

        // A new byte starting before the read data is loaded is an overrun;
        // the set has priority over a coincident clear.
        err_n = err;
        if (err_clr) begin
            err_n = 1'b0;
        end
        if (cs_fall && (state == FETCH || state == LOAD)) begin
            err_n = 1'b1;
        end

        case (state)
            IDLE: begin
                spi_p_in_n = status;
                if (cs_rise) begin
                    addr_n      = spi_p_out[ADDR_W-1:0];
                    remaining_n = spi_p_out[WIDTH-2 -: LEN_W];
                    is_read_n   = spi_p_out[WIDTH-1];
                    if (spi_p_out[WIDTH-1]) begin
                        state_n    = FETCH;
                        reg_re_n   = 1'b1;
                        reg_addr_n = spi_p_out[ADDR_W-1:0];
                    end else begin
                        state_n = DATA;
                    end
                end
            end

            FETCH: begin
                state_n = LOAD;
            end

            LOAD: begin
                spi_p_in_n = reg_rdata;
                state_n    = DATA;
            end

            DATA: begin
                if (cs_rise) begin
                    if (!is_read) begin
                        reg_we_n    = 1'b1;
                        reg_wdata_n = spi_p_out;
                        reg_addr_n  = addr;
                    end
                    if (remaining != '0) begin
                        remaining_n = remaining - LEN_W'(1);
                        addr_n      = addr + ADDR_W'(1);
                        if (is_read) begin
                            state_n    = FETCH;
                            reg_re_n   = 1'b1;
                            reg_addr_n = addr + ADDR_W'(1);
                        end
                    end else begin
                        state_n = IDLE;
                    end
                end
            end

            default: begin
                state_n = IDLE;
            end
        endcase
    end

    assign busy = (state != IDLE);

endmodule
